// File: rtl/mqfu_axi4_lite_slave.sv
// AXI4-Lite control-register slave for the MQFU filter core.
// Holds CTRL/STATUS/CFG/RESULT and sequences the core start/done handshake.
module mqfu_axi4_lite_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic                              core_start,
    input  logic                              core_busy,
    input  logic                              core_done,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     core_result,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     core_cfg,
    output logic                              irq
);

    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned SW = DW / 8;
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CFG    = 2'd2;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    logic          r_ready;
    logic          r_aw_held;
    logic          r_w_held;
    logic          r_bvalid;
    logic          r_rvalid;
    logic [AW-1:0] r_awaddr;
    logic [DW-1:0] r_wdata;
    logic [SW-1:0] r_wstrb;
    logic [DW-1:0] r_rdata;
    logic          r_irq_en;
    logic          r_done;
    logic          r_start_err;
    logic          r_core_start;
    logic          r_irq;
    logic [DW-1:0] r_cfg;
    logic [DW-1:0] r_result;

    logic          w_awready;
    logic          w_wready;
    logic          w_arready;
    logic          w_aw_hs;
    logic          w_w_hs;
    logic          w_ar_hs;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic [DW-1:0] w_wr_data;
    logic [SW-1:0] w_wr_strb;
    logic [1:0]    w_wr_sel;
    logic          w_ctrl_wr;
    logic          w_status_wr;
    logic          w_cfg_wr;
    logic          w_start_req;
    logic          w_start_ok;
    logic          w_start_err;
    logic          w_done_clr;
    logic          w_err_clr;
    logic [DW-1:0] w_rd_mux;
    logic          w_unused;

    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // Handshake qualifiers; a channel stays closed while its beat is held or a response is pending
    assign w_awready = r_ready & ~r_aw_held & ~r_bvalid;
    assign w_wready  = r_ready & ~r_w_held & ~r_bvalid;
    assign w_arready = r_ready & ~r_rvalid;
    assign w_aw_hs   = s00_axi_awvalid & w_awready;
    assign w_w_hs    = s00_axi_wvalid & w_wready;
    assign w_ar_hs   = s00_axi_arvalid & w_arready;
    assign w_wr_en   = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);

    assign w_wr_addr = r_aw_held ? r_awaddr : s00_axi_awaddr;
    assign w_wr_data = r_w_held ? r_wdata : s00_axi_wdata;
    assign w_wr_strb = r_w_held ? r_wstrb : s00_axi_wstrb;
    assign w_wr_sel  = w_wr_addr[3:2];

    assign w_ctrl_wr   = w_wr_en & (w_wr_sel == REG_CTRL) & w_wr_strb[0];
    assign w_status_wr = w_wr_en & (w_wr_sel == REG_STATUS) & w_wr_strb[0];
    assign w_cfg_wr    = w_wr_en & (w_wr_sel == REG_CFG);
    assign w_start_req = w_ctrl_wr & w_wr_data[0];
    assign w_start_ok  = w_start_req & ~core_busy;
    assign w_start_err = w_start_req & core_busy;
    assign w_done_clr  = w_status_wr & w_wr_data[1];
    assign w_err_clr   = w_status_wr & w_wr_data[2];

    // Read mux samples pre-edge register state, so same-cycle updates return the old value
    always_comb begin
        w_rd_mux = '0;
        case (s00_axi_araddr[3:2])
            REG_CTRL:   w_rd_mux[1] = r_irq_en;
            REG_STATUS: begin
                w_rd_mux[0] = core_busy;
                w_rd_mux[1] = r_done;
                w_rd_mux[2] = r_start_err;
            end
            REG_CFG:    w_rd_mux = r_cfg;
            default:    w_rd_mux = r_result;
        endcase
    end

    // Bus channel state
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_ready   <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
        end else begin
            r_ready <= 1'b1;
            if (w_wr_en) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_awaddr  <= s00_axi_awaddr;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= s00_axi_wdata;
                    r_wstrb  <= s00_axi_wstrb;
                end
                if (r_bvalid && s00_axi_bready) r_bvalid <= 1'b0;
            end
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_mux;
            end else if (r_rvalid && s00_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // Control/status registers; sticky flags give the set term priority over W1C
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_irq_en     <= 1'b0;
            r_done       <= 1'b0;
            r_start_err  <= 1'b0;
            r_core_start <= 1'b0;
            r_irq        <= 1'b0;
            r_cfg        <= '0;
            r_result     <= '0;
        end else begin
            r_core_start <= w_start_ok;
            if (w_ctrl_wr) r_irq_en <= w_wr_data[1];
            r_done      <= core_done | (r_done & ~w_done_clr);
            r_start_err <= w_start_err | (r_start_err & ~w_err_clr);
            if (core_done) r_result <= core_result;
            if (w_cfg_wr) begin
                for (int unsigned b = 0; b < SW; b++) begin
                    if (w_wr_strb[b]) r_cfg[8*b +: 8] <= w_wr_data[8*b +: 8];
                end
            end
            r_irq <= r_done & r_irq_en;
        end
    end

    assign s00_axi_awready = w_awready;
    assign s00_axi_wready  = w_wready;
    assign s00_axi_arready = w_arready;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_bresp   = RESP_OKAY;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rdata   = r_rdata;
    assign s00_axi_rresp   = RESP_OKAY;
    assign core_start      = r_core_start;
    assign core_cfg        = r_cfg;
    assign irq             = r_irq;

endmodule

// File: tb/tb_mqfu_axi4_lite_slave.sv
// Self-checking bench for mqfu_axi4_lite_slave: directed scenarios plus randomized
// register traffic compared against a register-map model.
module tb_mqfu_axi4_lite_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        core_start, irq;
    logic        core_busy = 0, core_done = 0;
    logic [31:0] core_result = '0, core_cfg;

    int n_checks = 0;
    int n_pass = 0;
    int start_cnt = 0;
    int start_bad = 0;
    logic prev_start = 0;

    // Reference model of the register map
    logic        m_irq_en = 0, m_done = 0, m_err = 0;
    logic [31:0] m_cfg = '0, m_result = '0;
    int          m_starts = 0;

    always #5 clk = ~clk;

    mqfu_axi4_lite_slave dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
        .core_result(core_result), .core_cfg(core_cfg), .irq(irq)
    );

    // Start pulses must be single-cycle and coincide with bvalid
    always @(negedge clk) begin
        if (rst_n && core_start) begin
            start_cnt++;
            if (!bvalid || prev_start) start_bad++;
        end
        prev_start = core_start;
    end

    function automatic logic [31:0] exp_read(input logic [3:0] a);
        logic [31:0] v;
        v = '0;
        case (a[3:2])
            2'd0: v[1] = m_irq_en;
            2'd1: begin v[0] = core_busy; v[1] = m_done; v[2] = m_err; end
            2'd2: v = m_cfg;
            default: v = m_result;
        endcase
        return v;
    endfunction

    task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        case (a[3:2])
            2'd0: if (s[0]) begin
                m_irq_en = d[1];
                if (d[0]) begin
                    if (core_busy) m_err = 1'b1;
                    else m_starts++;
                end
            end
            2'd1: if (s[0]) begin
                if (d[1]) m_done = 1'b0;
                if (d[2]) m_err = 1'b0;
            end
            2'd2: for (int b = 0; b < 4; b++) if (s[b]) m_cfg[8*b +: 8] = d[8*b +: 8];
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_irq_en = 0; m_done = 0; m_err = 0; m_cfg = '0; m_result = '0;
    endtask

    // Bus driver: starts and ends on a falling edge
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, output logic [1:0] resp);
        int cyc;
        bit aw_done, w_done, awhs, whs;
        aw_done = 0; w_done = 0; cyc = 0; resp = 2'b11;
        while (!(aw_done && w_done) && cyc < 100) begin
            if (!aw_done && cyc >= aw_dly) begin awvalid = 1; awaddr = a; end
            if (!w_done && cyc >= w_dly) begin wvalid = 1; wdata = d; wstrb = s; end
            awhs = awvalid && awready;
            whs = wvalid && wready;
            @(negedge clk);
            cyc++;
            if (awhs) begin aw_done = 1; awvalid = 0; end
            if (whs) begin w_done = 1; wvalid = 0; end
        end
        awvalid = 0; wvalid = 0;
        bready = 1; cyc = 0;
        while (!bvalid && cyc < 100) begin @(negedge clk); cyc++; end
        if (!bvalid) begin
            n_checks++;
            $display("FAIL write_timeout addr=%h bvalid=%b required 1", a, bvalid);
        end
        resp = bresp;
        @(negedge clk);
        bready = 0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
        int cyc;
        cyc = 0; arvalid = 1; araddr = a; rready = 1;
        while (!arready && cyc < 100) begin @(negedge clk); cyc++; end
        @(negedge clk);
        arvalid = 0;
        if (!rvalid) begin
            n_checks++;
            $display("FAIL read_timeout addr=%h rvalid=%b required 1", a, rvalid);
        end
        d = rdata; resp = rresp;
        @(negedge clk);
        rready = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0] r;
        n_checks++;
        if ({awready, wready, arready, bvalid, rvalid, core_start, irq} !== 7'b0)
            $display("FAIL reset_outs got %b required 0", {awready, wready, arready, bvalid, rvalid, core_start, irq});
        else n_pass++;
        n_checks++;
        if (core_cfg !== 32'h0) $display("FAIL reset_cfg got %h required 0", core_cfg); else n_pass++;
        rst_n = 1;
        #1;
        n_checks++;
        if (awready !== 1'b0) $display("FAIL ready_early got %b required 0", awready); else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({awready, wready, arready} !== 3'b111)
            $display("FAIL ready_release got %b required 111", {awready, wready, arready});
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), d, r);
            n_checks++;
            if (d !== 32'h0) $display("FAIL reset_reg%0d got %h required 0", i, d); else n_pass++;
        end
    endtask

    task automatic test_cfg();
        logic [31:0] d;
        logic [1:0] r, rr;
        axi_write(4'h8, 32'hA5A55A5A, 4'hF, 0, 0, r);
        model_write(4'h8, 32'hA5A55A5A, 4'hF);
        axi_read(4'h8, d, rr);
        n_checks++;
        if ({r, rr} !== 4'b0) $display("FAIL cfg_resp got %b/%b required 00", r, rr); else n_pass++;
        n_checks++;
        if (d !== 32'hA5A55A5A) $display("FAIL cfg_read got %h required a5a55a5a", d); else n_pass++;
        n_checks++;
        if (core_cfg !== 32'hA5A55A5A) $display("FAIL cfg_port got %h required a5a55a5a", core_cfg); else n_pass++;
        axi_write(4'h8, 32'h00001234, 4'h3, 1, 0, r);
        model_write(4'h8, 32'h00001234, 4'h3);
        axi_read(4'h8, d, rr);
        n_checks++;
        if (d !== 32'hA5A51234) $display("FAIL cfg_strobe got %h required a5a51234", d); else n_pass++;
    endtask

    task automatic test_w_before_aw();
        logic [31:0] v, d;
        logic [1:0] rr;
        v = $urandom;
        wvalid = 1; wdata = v; wstrb = 4'hF; awaddr = 4'h8;
        n_checks++;
        if (wready !== 1'b1) $display("FAIL wfirst_wready got %b required 1", wready); else n_pass++;
        @(negedge clk);
        wvalid = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({awready, wready, bvalid} !== 3'b100)
            $display("FAIL wfirst_held got %b required 100", {awready, wready, bvalid});
        else n_pass++;
        awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        n_checks++;
        if (bvalid !== 1'b1) $display("FAIL wfirst_bvalid got %b required 1", bvalid); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bvalid, awready, wready} !== 3'b100)
                $display("FAIL bstall_%0d got %b required 100", i, {bvalid, awready, wready});
            else n_pass++;
        end
        bready = 1;
        @(negedge clk);
        bready = 0;
        n_checks++;
        if (bvalid !== 1'b0) $display("FAIL bstall_release got %b required 0", bvalid); else n_pass++;
        model_write(4'h8, v, 4'hF);
        axi_read(4'h8, d, rr);
        n_checks++;
        if (d !== m_cfg) $display("FAIL wfirst_data got %h required %h", d, m_cfg); else n_pass++;
    endtask

    task automatic test_core_start();
        logic [31:0] d;
        logic [1:0] r;
        core_busy = 0;
        axi_write(4'h0, 32'h3, 4'hF, 0, 0, r);
        model_write(4'h0, 32'h3, 4'hF);
        n_checks++;
        if (start_cnt !== m_starts) $display("FAIL start_count got %0d required %0d", start_cnt, m_starts); else n_pass++;
        n_checks++;
        if (start_bad !== 0) $display("FAIL start_shape got %0d required 0", start_bad); else n_pass++;
        core_done = 1; core_result = 32'h3F800000;
        @(negedge clk);
        core_done = 0; core_result = $urandom;
        m_done = 1; m_result = 32'h3F800000;
        n_checks++;
        if (irq !== 1'b0) $display("FAIL irq_early got %b required 0", irq); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (irq !== (m_done & m_irq_en)) $display("FAIL irq_rise got %b required %b", irq, m_done & m_irq_en); else n_pass++;
        axi_read(4'h4, d, r);
        n_checks++;
        if (d !== 32'h2) $display("FAIL status_done got %h required 2", d); else n_pass++;
        axi_read(4'hC, d, r);
        n_checks++;
        if (d !== 32'h3F800000) $display("FAIL result_cap got %h required 3f800000", d); else n_pass++;
        axi_write(4'h4, 32'h2, 4'hF, 0, 0, r);
        model_write(4'h4, 32'h2, 4'hF);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL irq_clear got %b required 0", irq); else n_pass++;
        axi_read(4'h4, d, r);
        n_checks++;
        if (d !== exp_read(4'h4)) $display("FAIL status_w1c got %h required %h", d, exp_read(4'h4)); else n_pass++;
    endtask

    task automatic test_start_err();
        logic [31:0] d, nr;
        logic [1:0] r;
        core_busy = 1;
        axi_write(4'h0, 32'h1, 4'hF, 0, 2, r);
        model_write(4'h0, 32'h1, 4'hF);
        n_checks++;
        if (start_cnt !== m_starts) $display("FAIL busy_nostart got %0d required %0d", start_cnt, m_starts); else n_pass++;
        axi_read(4'h4, d, r);
        n_checks++;
        if (d !== 32'h5) $display("FAIL status_err got %h required 5", d); else n_pass++;
        // W1C of DONE and START_ERR while core_done fires in the commit cycle
        nr = $urandom;
        awvalid = 1; awaddr = 4'h4; wvalid = 1; wdata = 32'h6; wstrb = 4'hF;
        core_done = 1; core_result = nr;
        @(negedge clk);
        awvalid = 0; wvalid = 0; core_done = 0; bready = 1;
        n_checks++;
        if (bvalid !== 1'b1) $display("FAIL setwin_bvalid got %b required 1", bvalid); else n_pass++;
        @(negedge clk);
        bready = 0;
        m_done = 1; m_err = 0; m_result = nr;
        axi_read(4'h4, d, r);
        n_checks++;
        if (d !== 32'h3) $display("FAIL set_wins got %h required 3", d); else n_pass++;
        core_busy = 0;
        axi_write(4'h4, 32'h2, 4'h1, 0, 0, r);
        model_write(4'h4, 32'h2, 4'h1);
        axi_write(4'h4, 32'h2, 4'hE, 0, 0, r);
        model_write(4'h4, 32'h2, 4'hE);
        axi_read(4'h4, d, r);
        n_checks++;
        if (d !== exp_read(4'h4)) $display("FAIL strobe0_gate got %h required %h", d, exp_read(4'h4)); else n_pass++;
    endtask

    task automatic test_result_ro();
        logic [31:0] d;
        logic [1:0] r, rr;
        axi_write(4'hC, 32'hDEADBEEF, 4'hF, 0, 0, r);
        n_checks++;
        if (r !== 2'b00) $display("FAIL ro_bresp got %b required 00", r); else n_pass++;
        axi_read(4'hC, d, rr);
        n_checks++;
        if (d !== m_result) $display("FAIL ro_result got %h required %h", d, m_result); else n_pass++;
        axi_write(4'h0, 32'h1, 4'hF, 0, 0, r);
        model_write(4'h0, 32'h1, 4'hF);
        axi_read(4'h0, d, rr);
        n_checks++;
        if (d !== exp_read(4'h0) || d[0] !== 1'b0) $display("FAIL ctrl_read got %h required %h", d, exp_read(4'h0)); else n_pass++;
    endtask

    task automatic test_read_race();
        logic [31:0] d, nr;
        logic [1:0] r;
        nr = $urandom;
        arvalid = 1; araddr = 4'hC; rready = 1;
        core_done = 1; core_result = nr;
        @(negedge clk);
        arvalid = 0; core_done = 0;
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== m_result)
            $display("FAIL race_old got %b/%h required 1/%h", rvalid, rdata, m_result);
        else n_pass++;
        m_result = nr; m_done = 1;
        @(negedge clk);
        rready = 0;
        axi_read(4'hC, d, r);
        n_checks++;
        if (d !== nr) $display("FAIL race_new got %h required %h", d, nr); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        int nb, nr;
        v = $urandom;
        nb = 0; nr = 0;
        awvalid = 1; awaddr = 4'h8; wvalid = 1; wdata = v; wstrb = 4'hF; bready = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bvalid) nb++;
        end
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        bready = 0;
        model_write(4'h8, v, 4'hF);
        n_checks++;
        if (nb !== 5) $display("FAIL b2b_writes got %0d required 5", nb); else n_pass++;
        arvalid = 1; araddr = 4'h8; rready = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rvalid) begin
                nr++;
                n_checks++;
                if (rdata !== m_cfg) $display("FAIL b2b_rdata got %h required %h", rdata, m_cfg); else n_pass++;
            end
        end
        arvalid = 0;
        @(negedge clk);
        rready = 0;
        n_checks++;
        if (nr !== 5) $display("FAIL b2b_reads got %0d required 5", nr); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] d, v;
        logic [3:0] a, s;
        logic [1:0] r;
        for (int i = 0; i < 40; i++) begin
            core_busy = 1'($urandom_range(0, 1));
            a = 4'($urandom_range(0, 3) * 4);
            if ($urandom_range(0, 1) == 1) begin
                v = $urandom;
                s = 4'($urandom);
                axi_write(a, v, s, $urandom_range(0, 3), $urandom_range(0, 3), r);
                model_write(a, v, s);
                n_checks++;
                if (r !== 2'b00 || start_cnt !== m_starts || start_bad !== 0 || irq !== (m_done & m_irq_en))
                    $display("FAIL rnd_wr%0d resp=%b starts=%0d bad=%0d irq=%b required 00/%0d/0/%b",
                             i, r, start_cnt, start_bad, irq, m_starts, m_done & m_irq_en);
                else n_pass++;
            end else begin
                axi_read(a, d, r);
                n_checks++;
                if (d !== exp_read(a) || r !== 2'b00)
                    $display("FAIL rnd_rd%0d addr=%h got %h required %h", i, a, d, exp_read(a));
                else n_pass++;
            end
        end
        core_busy = 0;
    endtask

    task automatic test_reset_midread();
        logic [31:0] d;
        logic [1:0] r;
        arvalid = 1; araddr = 4'h8; rready = 0;
        @(negedge clk);
        arvalid = 0;
        n_checks++;
        if (rvalid !== 1'b1) $display("FAIL pend_rvalid got %b required 1", rvalid); else n_pass++;
        #2 rst_n = 0;
        #1;
        model_reset();
        n_checks++;
        if ({rvalid, bvalid, arready, awready, wready, irq} !== 6'b0 || core_cfg !== 32'h0)
            $display("FAIL async_reset got %b cfg=%h required 0", {rvalid, bvalid, arready, awready, wready, irq}, core_cfg);
        else n_pass++;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({rvalid, bvalid} !== 2'b00) $display("FAIL post_reset_%0d got %b required 00", i, {rvalid, bvalid}); else n_pass++;
        end
        axi_read(4'h8, d, r);
        n_checks++;
        if (d !== 32'h0) $display("FAIL post_reset_cfg got %h required 0", d); else n_pass++;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_cfg();
        test_w_before_aw();
        test_core_start();
        test_start_err();
        test_result_ro();
        test_read_race();
        test_back_to_back();
        test_random();
        test_reset_midread();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
